// File: rtl/uart_ram_bridge.sv
// -----------------------------------------------------------------------------
// uart_ram_bridge
//   Byte-stream command engine sitting between a UART byte receiver/transmitter
//   and an internal block RAM. A command is one header byte (bit7 = read,
//   bits[6:0] = burst length - 1), NUM_ADDR_BYTES address bytes (MSB first)
//   and, for writes, BPW bytes per word (MSB first). Reads stream each word
//   back MSB byte first over the tx valid/ready handshake. The address
//   auto-increments per word and wraps modulo the RAM depth.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rx_data      received byte, qualified by rx_valid
//   rx_valid     one-cycle strobe per received byte (no back-pressure)
//   tx_data      byte to transmit
//   tx_valid     tx_data valid; transfer on an edge with tx_valid & tx_ready
//   tx_ready     transmitter can accept a byte
//   busy         high in every state except IDLE
//   timeout_err  one-cycle pulse when a command is abandoned by the timeout
//
// States
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | waiting for a command byte
//   S_ADDR    | collecting the address bytes
//   S_WDATA   | collecting write data, one RAM write per completed word
//   S_RD_REQ  | RAM read enable for the current address
//   S_RD_WAIT | RAM output valid, load it into the tx shift register
//   S_RD_SEND | presenting bytes of the current word on tx
// -----------------------------------------------------------------------------
module uart_ram_bridge #(
  parameter int unsigned RAM_ADDR_BITS  = 8,
  parameter int unsigned RAM_WIDTH      = 8,
  parameter int unsigned NUM_ADDR_BYTES = 1,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned BPW        = RAM_WIDTH / 8;
  localparam int unsigned RAM_DEPTH  = 1 << RAM_ADDR_BITS;
  localparam int unsigned BCW        = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned ACW        = (NUM_ADDR_BYTES > 1) ? $clog2(NUM_ADDR_BYTES) : 1;
  localparam int unsigned TLOAD      = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned TW         = (TLOAD > 0) ? $clog2(TLOAD + 1) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [BCW-1:0] BYTE_LAST  = BCW'(BPW - 1);
  localparam logic [ACW-1:0] ADDR_LAST  = ACW'(NUM_ADDR_BYTES - 1);
  localparam logic [TW-1:0]  TIMER_LOAD = TW'(TLOAD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_SEND
  } state_t;

  state_t                   r_state;
  logic                     r_is_rd;
  logic [6:0]               r_len;
  logic [RAM_ADDR_BITS-1:0] r_addr;
  logic [ACW-1:0]           r_addr_cnt;
  logic [BCW-1:0]           r_byte_cnt;
  logic [RAM_WIDTH-1:0]     r_wshift;
  logic                     r_we;
  logic [RAM_ADDR_BITS-1:0] r_waddr;
  logic [RAM_WIDTH-1:0]     r_tx_shift;
  logic                     r_tx_valid;
  logic                     r_timeout_err;
  logic [TW-1:0]            r_timer;

  logic [RAM_WIDTH-1:0]     r_mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0]     r_rdata;

  logic                     w_ram_re;
  logic                     w_timeout;
  logic [RAM_WIDTH-1:0]     w_wshift_next;
  logic [RAM_ADDR_BITS-1:0] w_addr_shift;

  assign w_ram_re  = (r_state == S_RD_REQ);
  // Timer reaching zero only matters when no byte arrives on the same cycle;
  // the rx_valid branch is evaluated first in the FSM so the byte wins.
  assign w_timeout = TIMEOUT_EN && (r_timer == '0);

  // Shifting bytes in from the bottom and truncating keeps only the low
  // bits, which is exactly the MSB-first value modulo the target width.
  assign w_wshift_next = RAM_WIDTH'({r_wshift, rx_data});
  assign w_addr_shift  = RAM_ADDR_BITS'({r_addr, rx_data});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_is_rd       <= 1'b0;
      r_len         <= '0;
      r_addr        <= '0;
      r_addr_cnt    <= '0;
      r_byte_cnt    <= '0;
      r_wshift      <= '0;
      r_we          <= 1'b0;
      r_waddr       <= '0;
      r_tx_shift    <= '0;
      r_tx_valid    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_timer       <= '0;
    end else begin
      r_we          <= 1'b0;
      r_timeout_err <= 1'b0;

      if (rx_valid) begin
        r_timer <= TIMER_LOAD;
      end else if ((r_state == S_ADDR || r_state == S_WDATA) && r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_is_rd    <= rx_data[7];
            r_len      <= rx_data[6:0];
            r_addr_cnt <= '0;
            r_state    <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (rx_valid) begin
            r_addr <= w_addr_shift;
            if (r_addr_cnt == ADDR_LAST) begin
              r_byte_cnt <= '0;
              r_state    <= r_is_rd ? S_RD_REQ : S_WDATA;
            end else begin
              r_addr_cnt <= r_addr_cnt + 1'b1;
            end
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end
        end

        S_WDATA: begin
          if (rx_valid) begin
            r_wshift <= w_wshift_next;
            if (r_byte_cnt == BYTE_LAST) begin
              // Word complete: the RAM takes r_wshift/r_waddr on the next edge.
              r_we       <= 1'b1;
              r_waddr    <= r_addr;
              r_addr     <= r_addr + 1'b1;
              r_byte_cnt <= '0;
              if (r_len == '0) begin
                r_state <= S_IDLE;
              end else begin
                r_len <= r_len - 1'b1;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end else if (w_timeout) begin
            // Partial word is dropped; the next word fully overwrites r_wshift.
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end
        end

        S_RD_REQ: begin
          r_state <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          r_tx_shift <= r_rdata;
          r_tx_valid <= 1'b1;
          r_byte_cnt <= '0;
          r_state    <= S_RD_SEND;
        end

        S_RD_SEND: begin
          if (tx_ready) begin
            if (r_byte_cnt == BYTE_LAST) begin
              r_tx_valid <= 1'b0;
              r_addr     <= r_addr + 1'b1;
              if (r_len == '0) begin
                r_state <= S_IDLE;
              end else begin
                r_len   <= r_len - 1'b1;
                r_state <= S_RD_REQ;
              end
            end else begin
              r_tx_shift <= r_tx_shift << 8;
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Block RAM, contents not reset. r_we is cleared asynchronously by rst_n,
  // so a pending write is dropped when reset is low at the write edge.
  always_ff @(posedge clk) begin
    if (r_we) begin
      r_mem[r_waddr] <= r_wshift;
    end
    if (w_ram_re) begin
      r_rdata <= r_mem[r_addr];
    end
  end

  assign tx_data     = r_tx_shift[RAM_WIDTH-1 -: 8];
  assign tx_valid    = r_tx_valid;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_ram_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_ram_bridge
//   Drives command byte streams into uart_ram_bridge (16-bit words, 2 address
//   bytes, 256-word RAM, 50-cycle timeout) and compares read-back streams,
//   busy/tx handshake behaviour, timeouts and resets against a word-array
//   model of the RAM.
// -----------------------------------------------------------------------------
module tb_uart_ram_bridge;

  localparam int AB  = 8;
  localparam int W   = 16;
  localparam int NAB = 2;
  localparam int TO  = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       timeout_err;

  uart_ram_bridge #(
    .RAM_ADDR_BITS (AB),
    .RAM_WIDTH     (W),
    .NUM_ADDR_BYTES(NAB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_to  = 0;

  logic [15:0] m_mem [256];
  logic [15:0] wq [$];

  always @(negedge clk) if (timeout_err === 1'b1) n_to++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) step();
  endtask

  // Write burst of wq (len+1 words) at addr; gaps between bytes in [gmin,gmax].
  task automatic do_write(input int len, input logic [15:0] addr, input int gmin, input int gmax);
    logic [7:0] q [$];
    int a;
    chk("tx_idle_wr", tx_valid, 0);
    q.push_back(8'(len));
    q.push_back(addr[15:8]);
    q.push_back(addr[7:0]);
    for (int i = 0; i <= len; i++) begin
      q.push_back(wq[i][15:8]);
      q.push_back(wq[i][7:0]);
    end
    for (int i = 0; i < q.size(); i++) begin
      if (i == q.size() - 1) begin
        send_byte(q[i], 1);
        chk("busy_wr_end", busy, 0);
      end else begin
        send_byte(q[i], int'($urandom_range(gmax, gmin)));
        chk("busy_wr", busy, 1);
      end
    end
    a = int'(addr[7:0]);
    for (int i = 0; i <= len; i++) m_mem[(a + i) % 256] = wq[i];
  endtask

  // Read burst; tx_ready is held low for stall_len cycles when byte stall_at is due.
  task automatic do_read(input int len, input logic [15:0] addr, input int stall_at,
                         input int stall_len, input int maxgap);
    logic [7:0] exp [$];
    int got, budget, stalled, to0, a;
    logic prev_stall, rdy;
    logic [7:0] prev_data;
    a = int'(addr[7:0]);
    for (int i = 0; i <= len; i++) begin
      exp.push_back(m_mem[(a + i) % 256][15:8]);
      exp.push_back(m_mem[(a + i) % 256][7:0]);
    end
    chk("tx_idle_rd", tx_valid, 0);
    send_byte(8'h80 | 8'(len), int'($urandom_range(maxgap, 0)));
    send_byte(addr[15:8], int'($urandom_range(maxgap, 0)));
    send_byte(addr[7:0], 0);
    to0 = n_to;
    got = 0; budget = 0; stalled = 0; prev_stall = 1'b0; prev_data = 8'h00;
    while (got < exp.size() && budget < 300 + 12 * exp.size() + stall_len) begin
      if (prev_stall) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_data", tx_data, prev_data);
      end
      chk("busy_rd", busy, 1);
      if (tx_valid && got == stall_at && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end else begin
        rdy = ($urandom_range(3, 0) != 0);
      end
      tx_ready = rdy;
      if (tx_valid && rdy) begin
        chk($sformatf("rd_byte[%0d]", got), tx_data, exp[got]);
        got++;
      end
      prev_stall = tx_valid && !rdy;
      prev_data  = tx_data;
      step();
      budget++;
    end
    tx_ready = 1'b0;
    if (got < exp.size()) chk("rd_budget_bytes", got, exp.size());
    chk("tx_drop_after_last", tx_valid, 0);
    chk("busy_rd_end", busy, 0);
    chk("no_timeout_in_read", n_to, to0);
  endtask

  task automatic idle_watch(input int cycles, output int first, output int cnt);
    first = 0;
    cnt   = 0;
    for (int k = 1; k <= cycles; k++) begin
      step();
      if (timeout_err === 1'b1) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
  endtask

  task automatic reset_pulse(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, cnt, to0;

    // Reset values, during and after reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);

    // Fill the whole RAM with maximum bursts; upper address byte is ignored.
    wq = {};
    for (int i = 0; i < 128; i++) wq.push_back(16'(i));
    do_write(127, 16'h0000, 0, 2);
    wq = {};
    for (int i = 0; i < 128; i++) wq.push_back(16'($urandom));
    do_write(127, 16'h5A80, 0, 2);
    do_read(127, 16'h0000, -1, 0, 1);
    do_read(127, 16'h3380, 5, 3, 1);

    // Burst across the top of the RAM, with a 20-cycle stall mid-word.
    wq = {16'h1111, 16'h2222, 16'h3333};
    do_write(2, 16'h00FE, 0, 3);
    do_read(2, 16'h00FE, 1, 20, 2);
    do_read(0, 16'h0000, -1, 0, 0);
    // Back-pressure longer than the timeout is legal in reads.
    do_read(1, 16'h0010, 2, 70, 0);

    // Timeout in WDATA after one complete word and half of the next.
    to0 = n_to;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h20, 0);
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    send_byte(8'h99, 0);
    idle_watch(60, first, cnt);
    chk("to_wdata_cycle", first, 50);
    chk("to_wdata_pulses", cnt, 1);
    chk("to_wdata_busy", busy, 0);
    chk("to_wdata_monitor", n_to - to0, 1);
    m_mem[8'h20] = 16'h7788;
    do_read(1, 16'h0020, -1, 0, 1);

    // Timeout in ADDR.
    send_byte(8'h81, 0);
    send_byte(8'h00, 0);
    idle_watch(60, first, cnt);
    chk("to_addr_cycle", first, 50);
    chk("to_addr_pulses", cnt, 1);
    chk("to_addr_busy", busy, 0);

    // A byte arriving exactly on the would-be timeout cycle keeps the command alive.
    to0 = n_to;
    wq = {16'hBEEF};
    do_write(0, 16'h0030, 49, 49);
    chk("rx_wins_no_timeout", n_to, to0);
    do_read(0, 16'h0030, -1, 0, 0);

    // Reset after 1 of 2 bytes of a word.
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h40, 0);
    send_byte(8'hAB, 0);
    reset_pulse("rst_wdata");
    do_read(0, 16'h0040, -1, 0, 0);

    // Reset low on the edge where a completed word would be written.
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h41, 0);
    send_byte(8'hCD, 0);
    send_byte(8'hEF, 0);
    reset_pulse("rst_wedge");
    do_read(0, 16'h0041, -1, 0, 0);

    // Reset while a read byte is being presented.
    wq = {16'hA5C3};
    do_write(0, 16'h0005, 0, 0);
    send_byte(8'h80, 0);
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    cnt = 0;
    while (tx_valid !== 1'b1 && cnt < 10) begin
      step();
      cnt++;
    end
    chk("rst_rd_pre_valid", tx_valid, 1);
    chk("rst_rd_pre_data", tx_data, 8'hA5);
    reset_pulse("rst_read");
    do_read(0, 16'h0005, -1, 0, 0);

    // Randomized command mix.
    for (int n = 0; n < 40; n++) begin
      int len;
      logic [15:0] a;
      len = ($urandom_range(7, 0) == 0) ? int'($urandom_range(127, 0)) : int'($urandom_range(15, 0));
      a   = 16'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        do_read(len, a, int'($urandom_range(2 * len + 1, 0)), int'($urandom_range(60, 0)), 3);
      end else begin
        wq = {};
        for (int i = 0; i <= len; i++) wq.push_back(16'($urandom));
        do_write(len, a, 0, 5);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
